// File: rtl/nz_voice_arbiter.sv
// rtl/nz_voice_arbiter.sv - noise voice arbiter between music sequencer and sound-effect engine
// Optional feature macro: NZ_ARB_RESUME_EN (resume a pre-empted music note after the effect)
// cfg layout, MSB first: note[5:0], length[2:0], atk[1:0], dec[1:0], fx_sel[1:0], optA[1:0], optB[1:0] (19 bits)
module nz_voice_arbiter #(
  parameter int DUR_SCALE = 4,
  parameter int GAP_TICKS = 1,
  parameter int CNT_W     = 6
) (
  input  logic        clk50mhz,
  input  logic        rst,
  input  logic        note_tick,
  input  logic        mus_valid,
  output logic        mus_ready,
  input  logic [18:0] mus_cfg,
  input  logic        sfx_valid,
  output logic        sfx_ready,
  input  logic [18:0] sfx_cfg,
  output logic [5:0]  ch_note,
  output logic [2:0]  ch_length,
  output logic [1:0]  ch_atk,
  output logic [1:0]  ch_dec,
  output logic [1:0]  ch_fx_sel,
  output logic [1:0]  ch_optA,
  output logic [1:0]  ch_optB,
  output logic        ch_rst,
  output logic        owner,
  output logic        busy,
  output logic        done,
  output logic        preempt
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, PLAY = 2'd2, GAP = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [18:0]      cfg_q, cfg_nxt;
  logic             owner_nxt, done_nxt, preempt_nxt;
  logic [CNT_W-1:0] play_dur;

  // Full play length of a note in ticks, kept at counter width
  function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] len);
    return (CNT_W'(len) + CNT_W'(1)) * CNT_W'(DUR_SCALE);
  endfunction

`ifdef NZ_ARB_RESUME_EN
  logic             pend_q, pend_nxt;
  logic [18:0]      save_cfg_q, save_cfg_nxt;
  logic [CNT_W-1:0] save_left_q, save_left_nxt;
  logic [CNT_W-1:0] dur_q, dur_nxt;
  // A resumed note plays only its leftover ticks, so the target is latched per note
  assign play_dur = dur_q;
`else
  assign play_dur = dur_of(cfg_q[12:10]);
`endif

  assign ch_note   = cfg_q[18:13];
  assign ch_length = cfg_q[12:10];
  assign ch_atk    = cfg_q[9:8];
  assign ch_dec    = cfg_q[7:6];
  assign ch_fx_sel = cfg_q[5:4];
  assign ch_optA   = cfg_q[3:2];
  assign ch_optB   = cfg_q[1:0];
  assign ch_rst    = (state == START);
  assign busy      = (state != IDLE);

  // State, latched settings, tick counter and one-cycle status pulses
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cfg_q   <= '0;
      owner   <= 1'b0;
      done    <= 1'b0;
      preempt <= 1'b0;
`ifdef NZ_ARB_RESUME_EN
      pend_q      <= 1'b0;
      save_cfg_q  <= '0;
      save_left_q <= '0;
      dur_q       <= '0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cfg_q   <= cfg_nxt;
      owner   <= owner_nxt;
      done    <= done_nxt;
      preempt <= preempt_nxt;
`ifdef NZ_ARB_RESUME_EN
      pend_q      <= pend_nxt;
      save_cfg_q  <= save_cfg_nxt;
      save_left_q <= save_left_nxt;
      dur_q       <= dur_nxt;
`endif
    end
  end

  // Grant decisions, note timing and next-state selection
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cfg_nxt     = cfg_q;
    owner_nxt   = owner;
    done_nxt    = 1'b0;
    preempt_nxt = 1'b0;
    mus_ready   = 1'b0;
    sfx_ready   = 1'b0;
`ifdef NZ_ARB_RESUME_EN
    pend_nxt      = pend_q;
    save_cfg_nxt  = save_cfg_q;
    save_left_nxt = save_left_q;
    dur_nxt       = dur_q;
`endif
    case (state)
      IDLE: begin
        sfx_ready = 1'b1;
        mus_ready = !(mus_valid && sfx_valid);
`ifdef NZ_ARB_RESUME_EN
        if (pend_q) mus_ready = 1'b0;
`endif
        if (sfx_valid) begin
          cfg_nxt   = sfx_cfg;
          owner_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = START;
`ifdef NZ_ARB_RESUME_EN
          dur_nxt   = dur_of(sfx_cfg[12:10]);
        end else if (pend_q) begin
          cfg_nxt   = save_cfg_q;
          owner_nxt = 1'b0;
          cnt_nxt   = '0;
          dur_nxt   = save_left_q;
          pend_nxt  = 1'b0;
          state_nxt = START;
`endif
        end else if (mus_valid) begin
          cfg_nxt   = mus_cfg;
          owner_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = START;
`ifdef NZ_ARB_RESUME_EN
          dur_nxt   = dur_of(mus_cfg[12:10]);
`endif
        end
      end
      START: begin
        state_nxt = PLAY;
      end
      PLAY: begin
        sfx_ready = !owner;
        // Pre-emption outranks both a normal tick and the final tick of the note
        if (sfx_valid && !owner) begin
`ifdef NZ_ARB_RESUME_EN
          pend_nxt      = 1'b1;
          save_cfg_nxt  = cfg_q;
          save_left_nxt = play_dur - cnt;
          dur_nxt       = dur_of(sfx_cfg[12:10]);
`endif
          cfg_nxt     = sfx_cfg;
          owner_nxt   = 1'b1;
          cnt_nxt     = '0;
          preempt_nxt = 1'b1;
          state_nxt   = START;
        end else if (note_tick) begin
          if (cnt + CNT_W'(1) == play_dur) begin
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (note_tick) begin
          if (cnt + CNT_W'(1) == CNT_W'(GAP_TICKS)) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nz_voice_arbiter.sv
// tb/tb_nz_voice_arbiter.sv - self-checking bench for nz_voice_arbiter
module tb_nz_voice_arbiter;

  logic             clk50mhz;
  logic             rst;
  logic             note_tick;
  logic             mus_valid, sfx_valid;
  logic [18:0]      mus_cfg, sfx_cfg;
  logic [1:0]       mus_ready, sfx_ready, ch_rst, owner, busy, done, preempt;
  logic [1:0][18:0] ch_cfg;

  int checks = 0;
  int errors = 0;

`ifdef NZ_ARB_RESUME_EN
  localparam bit RESUME = 1'b1;
`else
  localparam bit RESUME = 1'b0;
`endif

  localparam int P_IDLE = 0, P_START = 1, P_PLAY = 2, P_GAP = 3;

  // Instance 0: DUR_SCALE 4, GAP_TICKS 1.  Instance 1: DUR_SCALE 2, GAP_TICKS 0.
  function automatic int dscale(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic int gticks(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  nz_voice_arbiter #(.DUR_SCALE(4), .GAP_TICKS(1), .CNT_W(6)) u_arb0 (
    .clk50mhz(clk50mhz), .rst(rst), .note_tick(note_tick),
    .mus_valid(mus_valid), .mus_ready(mus_ready[0]), .mus_cfg(mus_cfg),
    .sfx_valid(sfx_valid), .sfx_ready(sfx_ready[0]), .sfx_cfg(sfx_cfg),
    .ch_note(ch_cfg[0][18:13]), .ch_length(ch_cfg[0][12:10]), .ch_atk(ch_cfg[0][9:8]),
    .ch_dec(ch_cfg[0][7:6]), .ch_fx_sel(ch_cfg[0][5:4]), .ch_optA(ch_cfg[0][3:2]),
    .ch_optB(ch_cfg[0][1:0]), .ch_rst(ch_rst[0]), .owner(owner[0]), .busy(busy[0]),
    .done(done[0]), .preempt(preempt[0]));

  nz_voice_arbiter #(.DUR_SCALE(2), .GAP_TICKS(0), .CNT_W(5)) u_arb1 (
    .clk50mhz(clk50mhz), .rst(rst), .note_tick(note_tick),
    .mus_valid(mus_valid), .mus_ready(mus_ready[1]), .mus_cfg(mus_cfg),
    .sfx_valid(sfx_valid), .sfx_ready(sfx_ready[1]), .sfx_cfg(sfx_cfg),
    .ch_note(ch_cfg[1][18:13]), .ch_length(ch_cfg[1][12:10]), .ch_atk(ch_cfg[1][9:8]),
    .ch_dec(ch_cfg[1][7:6]), .ch_fx_sel(ch_cfg[1][5:4]), .ch_optA(ch_cfg[1][3:2]),
    .ch_optB(ch_cfg[1][1:0]), .ch_rst(ch_rst[1]), .owner(owner[1]), .busy(busy[1]),
    .done(done[1]), .preempt(preempt[1]));

  initial clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Reference model: one note record per instance with down-counting remaining ticks
  int          ph        [2];
  logic [18:0] m_cfg     [2];
  logic        m_owner   [2];
  logic        m_done    [2];
  logic        m_pre     [2];
  int          play_left [2];
  int          gap_left  [2];
  logic        m_sv      [2];
  logic [18:0] sv_cfg    [2];
  int          sv_left   [2];

  function automatic int full_ticks(input int i, input logic [18:0] c);
    return (int'(c[12:10]) + 1) * dscale(i);
  endfunction

  task automatic m_load(input int i, input logic [18:0] c, input logic own);
    m_cfg[i]     = c;
    m_owner[i]   = own;
    play_left[i] = full_ticks(i, c);
    ph[i]        = P_START;
  endtask

  task automatic m_reset(input int i);
    ph[i] = P_IDLE; m_cfg[i] = '0; m_owner[i] = 1'b0; m_done[i] = 1'b0; m_pre[i] = 1'b0;
    play_left[i] = 0; gap_left[i] = 0; m_sv[i] = 1'b0; sv_cfg[i] = '0; sv_left[i] = 0;
  endtask

  task automatic m_step(input int i);
    m_done[i] = 1'b0;
    m_pre[i]  = 1'b0;
    case (ph[i])
      P_IDLE: begin
        if (sfx_valid) m_load(i, sfx_cfg, 1'b1);
        else if (m_sv[i]) begin
          m_load(i, sv_cfg[i], 1'b0);
          play_left[i] = sv_left[i];
          m_sv[i] = 1'b0;
        end else if (mus_valid) m_load(i, mus_cfg, 1'b0);
      end
      P_START: ph[i] = P_PLAY;
      P_PLAY: begin
        if (sfx_valid && !m_owner[i]) begin
          if (RESUME) begin
            m_sv[i] = 1'b1; sv_cfg[i] = m_cfg[i]; sv_left[i] = play_left[i];
          end
          m_load(i, sfx_cfg, 1'b1);
          m_pre[i] = 1'b1;
        end else if (note_tick) begin
          play_left[i]--;
          if (play_left[i] == 0) begin
            m_done[i] = 1'b1;
            if (gticks(i) == 0) ph[i] = P_IDLE;
            else begin
              ph[i] = P_GAP;
              gap_left[i] = gticks(i);
            end
          end
        end
      end
      default: begin
        if (note_tick) begin
          gap_left[i]--;
          if (gap_left[i] == 0) ph[i] = P_IDLE;
        end
      end
    endcase
  endtask

  // Model advances on the same edges as the DUT, including the asynchronous reset
  always @(posedge clk50mhz or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) m_reset(i);
      else m_step(i);
    end
  end

  // Compare every output of both instances against the model on every falling edge
  always @(negedge clk50mhz) begin
    for (int i = 0; i < 2; i++) begin
      chk("ch_cfg", i, 32'(ch_cfg[i]), 32'(m_cfg[i]));
      chk("ch_rst", i, 32'(ch_rst[i]), 32'(ph[i] == P_START));
      chk("busy", i, 32'(busy[i]), 32'(ph[i] != P_IDLE));
      chk("owner", i, 32'(owner[i]), 32'(m_owner[i]));
      chk("done", i, 32'(done[i]), 32'(m_done[i]));
      chk("preempt", i, 32'(preempt[i]), 32'(m_pre[i]));
      chk("sfx_ready", i, 32'(sfx_ready[i]),
          32'((ph[i] == P_IDLE) || (ph[i] == P_PLAY && !m_owner[i])));
      chk("mus_ready", i, 32'(mus_ready[i]),
          32'((ph[i] == P_IDLE) && !(mus_valid && sfx_valid) && !m_sv[i]));
    end
  end

  task automatic cyc();
    @(posedge clk50mhz);
    #2;
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int k = 0; k < 400 && quiet < 2; k++) begin
      note_tick = ~note_tick;
      cyc();
      quiet = (busy == 2'b00) ? quiet + 1 : 0;
    end
    note_tick = 1'b0;
    chk("idle_wait", 0, 32'(quiet >= 2), 32'd1);
  endtask

  initial begin
    int found, seen;
    rst = 1'b1; note_tick = 1'b0; mus_valid = 1'b0; sfx_valid = 1'b0;
    mus_cfg = '0; sfx_cfg = '0;
    repeat (3) cyc();
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_note", 0, 32'(ch_cfg[0][18:13]), 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_mus_ready", 0, 32'(mus_ready[0]), 32'd1);

    // Music note 20, length 1: 8 ticks then one gap tick
    mus_cfg = {6'd20, 3'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mus_valid = 1'b1;
    cyc();
    mus_valid = 1'b0;
    chk("acc_note", 0, 32'(ch_cfg[0][18:13]), 32'd20);
    chk("acc_ch_rst", 0, 32'(ch_rst[0]), 32'd1);
    cyc();
    chk("play_ch_rst", 0, 32'(ch_rst[0]), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      note_tick = 1'b1;
      cyc();
      note_tick = 1'b0;
      if (k == 7) chk("done_early", 0, 32'(done[0]), 32'd0);
      if (k == 8) chk("done_tick8", 0, 32'(done[0]), 32'd1);
    end
    cyc();
    chk("gap_busy", 0, 32'(busy[0]), 32'd1);
    note_tick = 1'b1;
    cyc();
    note_tick = 1'b0;
    chk("gap_end_busy", 0, 32'(busy[0]), 32'd0);

    // Simultaneous requests: effect wins, music follows later
    wait_idle();
    sfx_cfg = {6'd45, 3'd0, 10'h155};
    mus_valid = 1'b1; sfx_valid = 1'b1;
    #1;
    chk("both_mus_ready", 0, 32'(mus_ready[0]), 32'd0);
    chk("both_sfx_ready", 0, 32'(sfx_ready[0]), 32'd1);
    cyc();
    sfx_valid = 1'b0;
    chk("both_owner", 0, 32'(owner[0]), 32'd1);
    chk("both_note", 0, 32'(ch_cfg[0][18:13]), 32'd45);
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      note_tick = ~note_tick;
      cyc();
      if (ch_rst[0] && !owner[0]) found = 1;
    end
    mus_valid = 1'b0; note_tick = 1'b0;
    chk("mus_after_sfx", 0, 32'(found), 32'd1);
    chk("mus_after_note", 0, 32'(ch_cfg[0][18:13]), 32'd20);

    // Pre-empt the music note after 3 of its 8 ticks
    cyc();
    for (int k = 0; k < 3; k++) begin
      note_tick = 1'b1;
      cyc();
      note_tick = 1'b0;
    end
    sfx_valid = 1'b1;
    cyc();
    sfx_valid = 1'b0;
    chk("pre_pulse", 0, 32'(preempt[0]), 32'd1);
    chk("pre_note", 0, 32'(ch_cfg[0][18:13]), 32'd45);
    chk("pre_ch_rst", 0, 32'(ch_rst[0]), 32'd1);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      note_tick = ~note_tick;
      cyc();
      if (ch_rst[0] && !owner[0]) found = 1;
    end
    chk("resume_seen", 0, 32'(found), 32'(RESUME));

    // Length 7: 32 counted ticks, the tick during START is ignored
    wait_idle();
    mus_cfg = {6'd33, 3'd7, 10'h2AA};
    mus_valid = 1'b1; note_tick = 1'b1;
    cyc();
    mus_valid = 1'b0;
    chk("len7_ch_rst", 0, 32'(ch_rst[0]), 32'd1);
    repeat (32) cyc();
    chk("len7_not_done", 0, 32'(done[0]), 32'd0);
    cyc();
    chk("len7_done", 0, 32'(done[0]), 32'd1);
    note_tick = 1'b0;

    // No-gap instance: next music accept the cycle after done
    wait_idle();
    mus_cfg = {6'd7, 3'd0, 10'h0};
    mus_valid = 1'b1; note_tick = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && seen < 2; k++) begin
      cyc();
      if (done[1]) begin
        cyc();
        chk("b2b_ch_rst", 1, 32'(ch_rst[1]), 32'd1);
        seen++;
      end
    end
    chk("b2b_seen", 1, 32'(seen), 32'd2);
    mus_valid = 1'b0; note_tick = 1'b0;

    // Reset in the middle of a playing note
    wait_idle();
    mus_cfg = {6'd50, 3'd7, 10'h0};
    mus_valid = 1'b1;
    cyc();
    mus_valid = 1'b0;
    note_tick = 1'b1;
    repeat (5) cyc();
    note_tick = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_note", 0, 32'(ch_cfg[0][18:13]), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
    chk("midrst_mus_ready", 0, 32'(mus_ready[0]), 32'd1);

    // Randomized traffic checked by the model
    for (int k = 0; k < 4000; k++) begin
      rst       = ($urandom_range(0, 499) == 0);
      mus_valid = $urandom_range(0, 1) == 1;
      sfx_valid = ($urandom_range(0, 7) == 0);
      note_tick = ($urandom_range(0, 2) == 0);
      mus_cfg   = 19'($urandom);
      sfx_cfg   = 19'($urandom);
      cyc();
    end
    rst = 1'b0; mus_valid = 1'b0; sfx_valid = 1'b0; note_tick = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
